// File: rtl/nmr_bstrm_pkg.sv
// Shared definitions for the NMR bitstream generator and capture blocks:
// FSM state encoding and command-word mode bit positions.
package nmr_bstrm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPT,
        ST_FLUSH,
        ST_ENDW
    } bstrm_state_e;

    // Mode bits sit directly above the data field; these are offsets from DATA_WIDTH.
    localparam int PATTERN_BIT = 0;
    localparam int ALL1_BIT    = 1;
    localparam int ALL0_BIT    = 2;
    localparam int SEQEND_BIT  = 3;

    function automatic int cmd_bit(input int data_width, input int ofs);
        return data_width + ofs;
    endfunction

endpackage

// File: rtl/nmr_bstrm_cap_rle.sv
// Run-length counter: tracks the current level and run length, and flags when
// the run must be emitted (level change or counter saturation).
module nmr_bstrm_cap_rle
    import nmr_bstrm_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 in_i,
    output logic                 emit_o,
    output logic                 level_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 level_q, level_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // A saturated run is emitted and restarted at the same level.
    assign emit_o  = step_i && ((in_i != level_q) || (cnt_q == CNT_MAX));
    assign level_o = level_q;
    assign cnt_o   = cnt_q;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            level_d = in_i;
            cnt_d   = CNT_ONE;
        end else if (step_i) begin
            if (emit_o) begin
                level_d = in_i;
                cnt_d   = CNT_ONE;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/nmr_bstrm_cap.sv
// Bitstream capture: run-length encodes IN into generator command words and
// streams them into an SRAM, closing the sequence with a seq_end word.
module nmr_bstrm_cap
    import nmr_bstrm_pkg::*;
#(
    parameter int DATA_WIDTH        = 120,
    parameter int CNT_WIDTH         = 32,
    parameter int SRAM_ADDR_WIDTH   = 8,
    parameter int SRAM_DAT_WIDTH    = 128,
    parameter int SRAM_BYTEEN_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         STOP,
    input  logic                         IN,
    output logic                         DONE,
    output logic                         OVF,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_WR,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN
);

    localparam int PATTERN_IDX = cmd_bit(DATA_WIDTH, PATTERN_BIT);
    localparam int ALL1_IDX    = cmd_bit(DATA_WIDTH, ALL1_BIT);
    localparam int ALL0_IDX    = cmd_bit(DATA_WIDTH, ALL0_BIT);
    localparam int SEQEND_IDX  = cmd_bit(DATA_WIDTH, SEQEND_BIT);

    localparam logic [SRAM_ADDR_WIDTH-1:0] PTR_LAST = '1;
    localparam logic [SRAM_ADDR_WIDTH-1:0] PTR_ONE  = SRAM_ADDR_WIDTH'(1);

    bstrm_state_e                   state_q, state_d;
    logic [SRAM_ADDR_WIDTH-1:0]     ptr_q, ptr_d;
    logic [SRAM_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic                           cs_q, cs_d;
    logic [SRAM_DAT_WIDTH-1:0]      dat_q, dat_d;
    logic [SRAM_BYTEEN_WIDTH-1:0]   byteen_q, byteen_d;
    logic                           done_q, done_d;
    logic                           ovf_q, ovf_d;
    logic                           ovf_pend_q, ovf_pend_d;

    logic                           rle_load, rle_step, rle_emit, rle_level;
    logic [CNT_WIDTH-1:0]           rle_cnt;
    logic [SRAM_DAT_WIDTH-1:0]      run_word, end_word, wr_word;
    logic                           wr_en;

    // Only the last address is left once it is reached, and it is reserved for seq_end.
    assign rle_load = (state_q == ST_IDLE) && START;
    assign rle_step = (state_q == ST_CAPT) && !STOP && (ptr_q != PTR_LAST);

    nmr_bstrm_cap_rle #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rle (
        .clk     (CLK),
        .rst     (RST),
        .load_i  (rle_load),
        .step_i  (rle_step),
        .in_i    (IN),
        .emit_o  (rle_emit),
        .level_o (rle_level),
        .cnt_o   (rle_cnt)
    );

    always_comb begin
        run_word                   = '0;
        run_word[DATA_WIDTH-1:0]   = DATA_WIDTH'(rle_cnt);
        run_word[PATTERN_IDX]      = 1'b0;
        run_word[ALL1_IDX]         = rle_level;
        run_word[ALL0_IDX]         = ~rle_level;
        end_word                   = '0;
        end_word[SEQEND_IDX]       = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        wr_en      = 1'b0;
        wr_word    = run_word;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_CAPT;
                    ptr_d      = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    ovf_pend_d = 1'b0;
                end
            end
            ST_CAPT: begin
                // Full outranks STOP so the end word always fits at the last address.
                if (ptr_q == PTR_LAST) begin
                    state_d    = ST_ENDW;
                    ovf_pend_d = 1'b1;
                    wr_en      = 1'b1;
                    wr_word    = end_word;
                end else if (STOP) begin
                    state_d = ST_FLUSH;
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + PTR_ONE;
                end else if (rle_emit) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            ST_FLUSH: begin
                state_d = ST_ENDW;
                wr_en   = 1'b1;
                wr_word = end_word;
            end
            ST_ENDW: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                ovf_d   = ovf_pend_q;
            end
            default: state_d = ST_IDLE;
        endcase

        cs_d     = wr_en;
        byteen_d = wr_en ? '1 : '0;
        addr_d   = wr_en ? ptr_q : addr_q;
        dat_d    = wr_en ? wr_word : dat_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            dat_q      <= '0;
            byteen_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            cs_q       <= cs_d;
            dat_q      <= dat_d;
            byteen_q   <= byteen_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    assign DONE        = done_q;
    assign OVF         = ovf_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CS     = cs_q;
    assign SRAM_WR     = cs_q;
    assign SRAM_WR_DAT = dat_q;
    assign SRAM_BYTEEN = byteen_q;

endmodule

// File: tb/tb_nmr_bstrm_cap.sv
// Bench for nmr_bstrm_cap with a small counter and SRAM so saturation and
// overflow are reached quickly; expected words come from a run-list model.
module tb_nmr_bstrm_cap;

    localparam int DW    = 120;
    localparam int CW    = 4;
    localparam int AW    = 3;
    localparam int SDW   = 128;
    localparam int BW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    logic           CLK = 1'b0;
    logic           RST, START, STOP, IN;
    logic           DONE, OVF;
    logic [AW-1:0]  SRAM_ADDR;
    logic           SRAM_CS, SRAM_WR;
    logic [SDW-1:0] SRAM_WR_DAT;
    logic [BW-1:0]  SRAM_BYTEEN;

    int n_chk = 0;
    int n_err = 0;

    bit             samp[$];
    logic [SDW-1:0] exp_q[$];
    bit             exp_ovf;
    logic [AW-1:0]  wq_addr[$];
    logic [SDW-1:0] wq_dat[$];

    nmr_bstrm_cap #(
        .DATA_WIDTH        (DW),
        .CNT_WIDTH         (CW),
        .SRAM_ADDR_WIDTH   (AW),
        .SRAM_DAT_WIDTH    (SDW),
        .SRAM_BYTEEN_WIDTH (BW)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .STOP        (STOP),
        .IN          (IN),
        .DONE        (DONE),
        .OVF         (OVF),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_CS     (SRAM_CS),
        .SRAM_WR     (SRAM_WR),
        .SRAM_WR_DAT (SRAM_WR_DAT),
        .SRAM_BYTEEN (SRAM_BYTEEN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (SRAM_CS === 1'b1) begin
            wq_addr.push_back(SRAM_ADDR);
            wq_dat.push_back(SRAM_WR_DAT);
            chk("wr_strobe", 128'({SRAM_WR, SRAM_BYTEEN}), 128'({1'b1, {BW{1'b1}}}));
        end
    end

    function automatic logic [SDW-1:0] mk_run(input bit lvl, input int len);
        logic [SDW-1:0] w;
        w         = '0;
        w[DW-1:0] = DW'(len);
        w[DW+1]   = lvl;
        w[DW+2]   = ~lvl;
        return w;
    endfunction

    function automatic logic [SDW-1:0] mk_end();
        logic [SDW-1:0] w;
        w       = '0;
        w[DW+3] = 1'b1;
        return w;
    endfunction

    task automatic add_run(input bit lvl, input int n);
        for (int k = 0; k < n; k++) samp.push_back(lvl);
    endtask

    // Maximal runs of the captured samples, each split into counter-sized chunks;
    // memory holds DEPTH-1 run words plus the end word.
    task automatic build_model();
        int lens[$];
        bit lv[$];
        exp_q.delete();
        for (int k = 0; k < samp.size(); k++) begin
            if (k == 0 || samp[k] != samp[k-1]) begin
                lens.push_back(1);
                lv.push_back(samp[k]);
            end else begin
                lens[lens.size()-1]++;
            end
        end
        for (int r = 0; r < lens.size(); r++) begin
            int rem;
            rem = lens[r];
            while (rem > 0) begin
                int c;
                c = (rem > CMAX) ? CMAX : rem;
                exp_q.push_back(mk_run(lv[r], c));
                rem -= c;
            end
        end
        exp_ovf = (exp_q.size() > DEPTH - 1);
        while (exp_q.size() > DEPTH - 1) void'(exp_q.pop_back());
        exp_q.push_back(mk_end());
    endtask

    // Called at a negedge; samp[0] is taken on the START edge, STOP edge sample is stop_in.
    task automatic run_capture(input string tag, input int start_pulse_at, input bit stop_in);
        int guard;
        int n;
        build_model();
        wq_addr.delete();
        wq_dat.delete();
        START = 1'b1;
        STOP  = 1'b0;
        IN    = samp[0];
        @(negedge CLK);
        START = 1'b0;
        chk({tag, ":flags_clr"}, 128'({DONE, OVF}), 128'(2'b00));
        for (int i = 1; i < samp.size(); i++) begin
            IN    = samp[i];
            START = (i == start_pulse_at);
            @(negedge CLK);
        end
        START = 1'b0;
        STOP  = 1'b1;
        IN    = stop_in;
        @(negedge CLK);
        STOP  = 1'b0;
        guard = 0;
        while (DONE !== 1'b1 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        repeat (4) @(negedge CLK);
        chk({tag, ":done_ovf"}, 128'({DONE, OVF}), 128'({1'b1, exp_ovf}));
        chk({tag, ":nwr"}, 128'(wq_dat.size()), 128'(exp_q.size()));
        n = (wq_dat.size() < exp_q.size()) ? wq_dat.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s:addr%0d", tag, i), 128'(wq_addr[i]), 128'(i));
            chk($sformatf("%s:dat%0d", tag, i), 128'(wq_dat[i]), 128'(exp_q[i]));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ":cs_wr"}, 128'({SRAM_CS, SRAM_WR}), 128'(2'b00));
        chk({tag, ":addr"}, 128'(SRAM_ADDR), 128'(0));
        chk({tag, ":dat"}, 128'(SRAM_WR_DAT), 128'(0));
        chk({tag, ":byteen"}, 128'(SRAM_BYTEEN), 128'(0));
        chk({tag, ":done_ovf"}, 128'({DONE, OVF}), 128'(2'b00));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        STOP  = 1'b0;
        IN    = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_state("reset");
        RST = 1'b0;
        @(negedge CLK);

        samp.delete(); add_run(1, 5); add_run(0, 3);
        run_capture("basic", -1, 1'($urandom_range(0, 1)));

        // STOP in IDLE must not write or clear flags
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_stop", 128'({DONE, wq_dat.size() == exp_q.size()}), 128'(2'b11));

        samp.delete(); add_run(0, 20);
        run_capture("saturate", -1, 1'($urandom_range(0, 1)));

        samp.delete();
        for (int i = 0; i < 16; i++) samp.push_back(bit'(~i[0]));
        run_capture("full", -1, 1'b0);

        samp.delete(); add_run(1, 4);
        run_capture("stop_edge", -1, 1'b0);

        samp.delete(); add_run(1, 3); add_run(0, 2); add_run(1, 2);
        run_capture("start_in_capt", 3, 1'($urandom_range(0, 1)));

        // Reset while the second run word is on the bus
        wq_addr.delete();
        wq_dat.delete();
        START = 1'b1; IN = 1'b1;
        @(negedge CLK);
        START = 1'b0; IN = 1'b1;
        @(negedge CLK);
        IN = 1'b0;
        @(negedge CLK);
        IN = 1'b0;
        @(negedge CLK);
        IN = 1'b1;
        @(negedge CLK);
        chk("rst_mid:cs_before", 128'(SRAM_CS), 128'(1));
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_state("rst_mid");
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_mid:nwr", 128'(wq_dat.size()), 128'(2));

        samp.delete(); add_run(1, 5); add_run(0, 3);
        run_capture("after_rst", -1, 1'($urandom_range(0, 1)));

        for (int t = 0; t < 40; t++) begin
            int  nruns;
            bit  lvl;
            nruns = $urandom_range(1, 10);
            lvl   = 1'($urandom_range(0, 1));
            samp.delete();
            for (int r = 0; r < nruns; r++) begin
                add_run(lvl, $urandom_range(1, 35));
                lvl = ~lvl;
            end
            run_capture($sformatf("rand%0d", t), -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nmr_bstrm_cap.md
NMR_BSTRM_CAP -- requirements
Module: nmr_bstrm_cap

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 120: data field width of a command word.
- CNT_WIDTH, 32: run-length counter width.
- SRAM_ADDR_WIDTH, 8: SRAM address width.
- SRAM_DAT_WIDTH, 128: SRAM data width.
- SRAM_BYTEEN_WIDTH, 16: SRAM byte-enable width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1: the single clock.
- RST, in, 1: synchronous, active-high reset.
- START, in, 1: begin capture.
- STOP, in, 1: end capture.
- IN, in, 1: bitstream sampled on each CLK rising edge.
- DONE, out, 1: capture finished.
- OVF, out, 1: capture ended because the SRAM was full.
- SRAM_ADDR, out, SRAM_ADDR_WIDTH: SRAM address.
- SRAM_CS, out, 1: SRAM chip select.
- SRAM_WR, out, 1: SRAM write strobe.
- SRAM_WR_DAT, out, SRAM_DAT_WIDTH: SRAM write data.
- SRAM_BYTEEN, out, SRAM_BYTEEN_WIDTH: SRAM byte enables.
REQ-003 Command word layout, as consumed by the bitstream generator:
- [DATA_WIDTH-1:0] = data.
- bit DATA_WIDTH = pattern_mode, always 0.
- bit DATA_WIDTH+1 = all_1s_mode.
- bit DATA_WIDTH+2 = all_0s_mode.
- bit DATA_WIDTH+3 = seq_end.
- remaining bits = 0.

Function
REQ-004 Block shall run-length encode IN into command words: a run of N identical samples (N >= 1) produces one word with data = N zero-extended, and all_1s_mode = level, all_0s_mode = ~level.
REQ-005 FSM states:
- IDLE -> CAPT on START.
- CAPT -> FLUSH on STOP.
- CAPT -> ENDW on full.
- FLUSH -> ENDW.
- ENDW -> IDLE.
REQ-006 On START in IDLE: address pointer = 0, DONE and OVF cleared, run level = IN sampled at that edge, count = 1.
REQ-007 Each CAPT edge, with no STOP: if IN equals level and count < 2^CNT_WIDTH-1, count increments; otherwise the current run word is written, then level = IN and count = 1.
REQ-008 Saturation: a run longer than 2^CNT_WIDTH-1 shall emit a word with data = 2^CNT_WIDTH-1 and continue as a new run of the same level.
REQ-009 Write timing: a word is driven on SRAM_ADDR/SRAM_WR_DAT with SRAM_CS = SRAM_WR = 1 and SRAM_BYTEEN all ones for exactly one cycle, starting the cycle after the terminating edge; the address pointer then increments by 1.
REQ-010 STOP in CAPT: the IN sample of the STOP edge is discarded; STOP overrides a simultaneous level change or saturation. FLUSH writes the pending run word.
REQ-011 ENDW writes a word with seq_end = 1, all other bits 0, at the next address, then sets DONE = 1.
REQ-012 Full: once a run word is written at address 2^SRAM_ADDR_WIDTH-2, the FSM enters ENDW regardless of IN, writes the end word at 2^SRAM_ADDR_WIDTH-1, and sets OVF = 1 with DONE. The address shall never wrap.
REQ-013 START outside IDLE shall be ignored. STOP outside CAPT shall be ignored.
REQ-014 DONE and OVF shall hold until the next accepted START or RST.
REQ-015 SRAM_CS = 0 in all non-write cycles. SRAM_WR_DAT is don't-care when SRAM_CS = 0.

Reset
REQ-016 On RST, at any point including mid-write: state = IDLE, SRAM_CS = SRAM_WR = 0, SRAM_ADDR = 0, SRAM_WR_DAT = 0, SRAM_BYTEEN = 0, DONE = 0, OVF = 0, count = 0. No end word shall be written.

Structure
REQ-017 Shared package nmr_bstrm_pkg shall hold the FSM state enum and the word-layout bit-index constants (PATTERN_BIT, ALL1_BIT, ALL0_BIT, SEQEND_BIT), so that generator and capture share one definition.
REQ-018 One sub-module, nmr_bstrm_cap_rle, shall hold the run-length counter with saturation. The top level holds the FSM, the address pointer and the SRAM port registers.

Verification
REQ-019 START with IN = 1 for 5 samples, then 0 for 3, then STOP -> addr0: all_1s, data = 5; addr1: all_0s, data = 3; addr2: seq_end; DONE = 1, OVF = 0.
REQ-020 CNT_WIDTH = 4, IN = 0 for 20 samples, then STOP -> addr0: data = 15; addr1: data = 5 (both all_0s); addr2: seq_end.
REQ-021 SRAM_ADDR_WIDTH = 3, IN toggling every cycle -> addr0..6 each data = 1 with alternating mode; addr7: seq_end; OVF = 1, DONE = 1; no further SRAM_CS.
REQ-022 STOP on the same edge IN changes 1->0 after 4 ones -> addr0: all_1s, data = 4; addr1: seq_end; no all_0s word.
REQ-023 RST asserted during CAPT after 2 words -> next cycle SRAM_CS = 0 and DONE = 0; a new START writes from addr0.
REQ-024 START pulsed during CAPT -> no address reset and no change to the word stream.
